// File: rtl/piso_stream_pkg.sv
// ---------------------------------------------------------------------------
// piso_stream_pkg
//   Shared definitions for the parallel-in/serial-out streaming block.
//
//   Contents:
//     clog2()        - ceiling log2, used to size the word counter
//     piso_state_t   - two-state FSM type (IDLE / SHIFT)
//     ST_IDLE        - no frame loaded, output side idle
//     ST_SHIFT       - frame loaded, words being presented on the output
//     PISO_*_POLY    - default width pair for the polynomial packer path
//     PISO_*_HASH    - default width pair for the hash-absorb path
// ---------------------------------------------------------------------------
package piso_stream_pkg;

  // Ceiling log2 with a floor of 0; bounded loop so it folds at elaboration.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  typedef logic piso_state_t;

  localparam piso_state_t ST_IDLE  = 1'b0;
  localparam piso_state_t ST_SHIFT = 1'b1;

  // Width pairs used by the packers feeding this block.
  localparam int unsigned PISO_N_POLY = 1344;
  localparam int unsigned PISO_M_POLY = 64;
  localparam int unsigned PISO_N_HASH = 256;
  localparam int unsigned PISO_M_HASH = 64;

endpackage

// File: rtl/piso_stream.sv
// ---------------------------------------------------------------------------
// piso_stream
//   Accepts one N-bit word over a valid/ready handshake and emits it as
//   K = N/M words of M bits over a valid/ready handshake with back-pressure.
//   The final word of each frame is flagged with out_last. Word order is
//   selectable: MSB_FIRST=1 emits in_data[N-1:N-M] first, MSB_FIRST=0 emits
//   in_data[M-1:0] first. A new frame can be loaded on the same edge that the
//   last word of the current frame is accepted, so back-to-back frames stream
//   without a bubble.
//
// Parameters:
//   N          parallel input width (N % M == 0, N / M >= 2)
//   M          serial output word width
//   MSB_FIRST  word order select
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   in_data is valid
//   in_ready   block can accept a parallel word this cycle
//   in_data    N-bit parallel word
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data this cycle
//   out_data   current M-bit serial word
//   out_last   high with the final word of a frame
//   busy       a frame is loaded and not fully emitted
// ---------------------------------------------------------------------------
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int unsigned N         = PISO_N_POLY,
  parameter int unsigned M         = PISO_M_POLY,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned K  = N / M;
  localparam int unsigned CW = clog2(K);

  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  if (((N % M) != 0) || ((N / M) < 2)) begin : g_bad_params
    $error("piso_stream: N must be a multiple of M with N/M >= 2");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  piso_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sreg;

  piso_state_t   w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_sreg_nxt;

  logic          w_out_valid;
  logic          w_out_last;
  logic          w_xfer;
  logic          w_load;
  logic [N-1:0]  w_sreg_shifted;
  logic [M-1:0]  w_head;

  // -------------------------------------------------------------------------
  // Word-order dependent datapath: which end of sreg is the output end and
  // which way the remaining words move after a transfer.
  // -------------------------------------------------------------------------
  if (MSB_FIRST) begin : g_msb_first
    assign w_head         = r_sreg[N-1 -: M];
    assign w_sreg_shifted = {r_sreg[N-M-1:0], {M{1'b0}}};
  end else begin : g_lsb_first
    assign w_head         = r_sreg[M-1:0];
    assign w_sreg_shifted = {{M{1'b0}}, r_sreg[N-1:M]};
  end

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // out_valid and out_last come straight from registers so neither depends
  // on out_ready; only in_ready looks at out_ready, to allow a reload on the
  // same edge that the last word leaves.
  assign w_out_valid = (r_state == ST_SHIFT);
  assign w_out_last  = w_out_valid && (r_cnt == CNT_LAST);
  assign w_xfer      = w_out_valid && out_ready;

  assign in_ready = !rst && ((r_state == ST_IDLE) || (w_xfer && w_out_last));
  assign w_load   = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sreg_nxt  = r_sreg;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_sreg_nxt  = in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_xfer) begin
          if (w_out_last) begin
            w_cnt_nxt = '0;
            if (w_load) begin
              // Reload in place: the next frame's first word is presented on
              // the very next cycle.
              w_sreg_nxt = in_data;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_sreg_nxt = w_sreg_shifted;
            w_cnt_nxt  = r_cnt + CW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sreg  <= w_sreg_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // out_data is driven from sreg in every state; sinks ignore it while
  // out_valid is low.
  assign out_valid = w_out_valid;
  assign out_last  = w_out_last;
  assign out_data  = w_head;
  assign busy      = w_out_valid;

endmodule
